// File: rtl/alu_operand_collector.sv
// Gathers a command and its operands across one or more upstream beats and
// issues them to the ALU as a single registered strobe.
//   state | meaning
//   IDLE  | ready for a new command beat
//   WAIT  | command held, waiting for missing operand(s)
//   ISSUE | one-cycle ALU_CE strobe, upstream stalled
module alu_operand_collector #(
  parameter int WIDTH   = 8,
  parameter int CWIDTH  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CWIDTH-1:0] IN_CMD,
  input  logic              IN_MODE,
  input  logic              IN_CIN,
  input  logic [WIDTH-1:0]  IN_OPA,
  input  logic [WIDTH-1:0]  IN_OPB,
  input  logic [1:0]        IN_OPV,
  output logic [WIDTH-1:0]  ALU_OPA,
  output logic [WIDTH-1:0]  ALU_OPB,
  output logic [CWIDTH-1:0] ALU_CMD,
  output logic              ALU_MODE,
  output logic              ALU_CIN,
  output logic [1:0]        ALU_INP_VALID,
  output logic              ALU_CE,
  output logic              CMD_ERR,
  output logic              TO_ERR,
  output logic              BUSY
);

  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]        r_have, w_have_nxt;
  logic [1:0]        r_mask, w_mask_nxt;
  logic [WIDTH-1:0]  r_opa, w_opa_nxt;
  logic [WIDTH-1:0]  r_opb, w_opb_nxt;
  logic [CWIDTH-1:0] r_cmd, w_cmd_nxt;
  logic              r_mode, w_mode_nxt;
  logic              r_cin, w_cin_nxt;
  logic              w_cmd_err, w_to_err;
  logic              w_accept;
  logic [1:0]        w_req, w_take;

  logic              r_in_ready, r_alu_ce, r_cmd_err, r_to_err, r_busy;
  logic              r_alu_mode, r_alu_cin;
  logic [WIDTH-1:0]  r_alu_opa, r_alu_opb;
  logic [CWIDTH-1:0] r_alu_cmd;
  logic [1:0]        r_alu_inp_valid;

  // Required-operand mask; 2'b00 marks an unsupported command.
  function automatic logic [1:0] req_mask(input logic mode, input logic [CWIDTH-1:0] cmd);
    logic [1:0]  m;
    int unsigned c;
    c = 32'(cmd);
    m = 2'b00;
    if (mode) begin
      if (c <= 3 || (c >= 8 && c <= 12)) m = 2'b11;
      else if (c == 4 || c == 5)         m = 2'b01;
      else if (c == 6 || c == 7)         m = 2'b10;
    end else begin
      if (c <= 5 || c == 12 || c == 13)  m = 2'b11;
      else if (c == 6 || c == 8 || c == 9)   m = 2'b01;
      else if (c == 7 || c == 10 || c == 11) m = 2'b10;
    end
    return m;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_have_nxt  = r_have;
    w_mask_nxt  = r_mask;
    w_opa_nxt   = r_opa;
    w_opb_nxt   = r_opb;
    w_cmd_nxt   = r_cmd;
    w_mode_nxt  = r_mode;
    w_cin_nxt   = r_cin;
    w_cmd_err   = 1'b0;
    w_to_err    = 1'b0;
    w_accept    = IN_VALID & r_in_ready;
    w_req       = req_mask(IN_MODE, IN_CMD);
    w_take      = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req == 2'b00) begin
            w_cmd_err = 1'b1;
          end else begin
            w_cmd_nxt  = IN_CMD;
            w_mode_nxt = IN_MODE;
            w_cin_nxt  = IN_CIN;
            w_mask_nxt = w_req;
            w_have_nxt = IN_OPV & w_req;
            if (IN_OPV[0]) w_opa_nxt = IN_OPA;
            if (IN_OPV[1]) w_opb_nxt = IN_OPB;
            w_cnt_nxt  = '0;
            w_state_nxt = ((IN_OPV & w_req) == w_req) ? S_ISSUE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // First arrival wins: only required, not-yet-held lanes are taken.
        if (w_accept) w_take = IN_OPV & r_mask & ~r_have;
        if (w_take[0]) w_opa_nxt = IN_OPA;
        if (w_take[1]) w_opb_nxt = IN_OPB;
        w_have_nxt = r_have | w_take;
        if ((w_have_nxt & r_mask) == r_mask) begin
          w_state_nxt = S_ISSUE;
        end else if (r_cnt == CNT_LAST) begin
          w_to_err    = 1'b1;
          w_state_nxt = S_IDLE;
          w_have_nxt  = 2'b00;
          w_mask_nxt  = 2'b00;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_IDLE;
        w_have_nxt  = 2'b00;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_have_nxt  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_have          <= 2'b00;
      r_mask          <= 2'b00;
      r_opa           <= '0;
      r_opb           <= '0;
      r_cmd           <= '0;
      r_mode          <= 1'b0;
      r_cin           <= 1'b0;
      r_in_ready      <= 1'b1;
      r_alu_ce        <= 1'b0;
      r_cmd_err       <= 1'b0;
      r_to_err        <= 1'b0;
      r_busy          <= 1'b0;
      r_alu_opa       <= '0;
      r_alu_opb       <= '0;
      r_alu_cmd       <= '0;
      r_alu_mode      <= 1'b0;
      r_alu_cin       <= 1'b0;
      r_alu_inp_valid <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_have     <= w_have_nxt;
      r_mask     <= w_mask_nxt;
      r_opa      <= w_opa_nxt;
      r_opb      <= w_opb_nxt;
      r_cmd      <= w_cmd_nxt;
      r_mode     <= w_mode_nxt;
      r_cin      <= w_cin_nxt;
      r_in_ready <= (w_state_nxt != S_ISSUE);
      r_alu_ce   <= (w_state_nxt == S_ISSUE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_cmd_err  <= w_cmd_err;
      r_to_err   <= w_to_err;
      // ALU data lanes only move on issue and hold otherwise.
      if (w_state_nxt == S_ISSUE) begin
        r_alu_opa       <= w_mask_nxt[0] ? w_opa_nxt : '0;
        r_alu_opb       <= w_mask_nxt[1] ? w_opb_nxt : '0;
        r_alu_cmd       <= w_cmd_nxt;
        r_alu_mode      <= w_mode_nxt;
        r_alu_cin       <= w_cin_nxt;
        r_alu_inp_valid <= w_mask_nxt;
      end
    end
  end

  assign IN_READY      = r_in_ready;
  assign ALU_OPA       = r_alu_opa;
  assign ALU_OPB       = r_alu_opb;
  assign ALU_CMD       = r_alu_cmd;
  assign ALU_MODE      = r_alu_mode;
  assign ALU_CIN       = r_alu_cin;
  assign ALU_INP_VALID = r_alu_inp_valid;
  assign ALU_CE        = r_alu_ce;
  assign CMD_ERR       = r_cmd_err;
  assign TO_ERR        = r_to_err;
  assign BUSY          = r_busy;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector: inputs change and outputs are
// sampled on the falling edge, one posedge between drive and check.
module tb_alu_operand_collector;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] IN_CMD;
  logic       IN_MODE;
  logic       IN_CIN;
  logic [7:0] IN_OPA;
  logic [7:0] IN_OPB;
  logic [1:0] IN_OPV;
  logic [7:0] ALU_OPA;
  logic [7:0] ALU_OPB;
  logic [3:0] ALU_CMD;
  logic       ALU_MODE;
  logic       ALU_CIN;
  logic [1:0] ALU_INP_VALID;
  logic       ALU_CE;
  logic       CMD_ERR;
  logic       TO_ERR;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;
  int bad;

  alu_operand_collector #(.WIDTH(8), .CWIDTH(4), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CMD(IN_CMD),
    .IN_MODE(IN_MODE), .IN_CIN(IN_CIN), .IN_OPA(IN_OPA), .IN_OPB(IN_OPB),
    .IN_OPV(IN_OPV),
    .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CMD(ALU_CMD),
    .ALU_MODE(ALU_MODE), .ALU_CIN(ALU_CIN), .ALU_INP_VALID(ALU_INP_VALID),
    .ALU_CE(ALU_CE), .CMD_ERR(CMD_ERR), .TO_ERR(TO_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic beat(input logic mode, input logic [3:0] cmd, input logic cin,
                      input logic [1:0] opv, input logic [7:0] a, input logic [7:0] b);
    IN_VALID = 1'b1; IN_MODE = mode; IN_CMD = cmd; IN_CIN = cin;
    IN_OPV = opv; IN_OPA = a; IN_OPB = b;
  endtask

  task automatic idle_in();
    IN_VALID = 1'b0; IN_OPV = 2'b00; IN_CMD = 4'd0; IN_MODE = 1'b0;
    IN_CIN = 1'b0; IN_OPA = 8'h00; IN_OPB = 8'h00;
  endtask

  initial begin
    RST = 1'b1;
    idle_in();
    @(negedge CLK);
    cyc();
    chk("rst_ready", IN_READY, 1);
    chk("rst_ce", ALU_CE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_errs", {CMD_ERR, TO_ERR}, 0);
    chk("rst_data", {ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_INP_VALID}, 0);
    RST = 1'b0;
    cyc();

    // Full beat issues the cycle after acceptance.
    beat(1'b1, 4'd0, 1'b1, 2'b11, 8'h12, 8'h34);
    cyc();
    chk("full_ce", ALU_CE, 1);
    chk("full_ops", {ALU_OPA, ALU_OPB}, 16'h1234);
    chk("full_ctl", {ALU_CMD, ALU_MODE, ALU_CIN, ALU_INP_VALID}, {4'd0, 1'b1, 1'b1, 2'b11});
    chk("full_ready_busy", {IN_READY, BUSY}, 2'b01);
    idle_in();
    cyc();
    chk("full_after", {ALU_CE, IN_READY, BUSY}, 3'b010);
    chk("full_hold", {ALU_OPA, ALU_OPB}, 16'h1234);

    // Split beat: A now, B three cycles later; second beat's cmd/mode/cin ignored.
    beat(1'b0, 4'd12, 1'b0, 2'b01, 8'hA5, 8'h77);
    cyc();
    chk("split_wait", {ALU_CE, BUSY, IN_READY}, 3'b011);
    idle_in();
    bad = 0;
    repeat (2) begin
      cyc();
      if (ALU_CE !== 1'b0 || TO_ERR !== 1'b0) bad++;
    end
    beat(1'b1, 4'd5, 1'b1, 2'b10, 8'h11, 8'h03);
    cyc();
    chk("split_early", bad, 0);
    chk("split_ce", {ALU_CE, TO_ERR}, 2'b10);
    chk("split_ops", {ALU_OPA, ALU_OPB}, 16'hA503);
    chk("split_ctl", {ALU_CMD, ALU_MODE, ALU_CIN, ALU_INP_VALID}, {4'd12, 1'b0, 1'b0, 2'b11});
    idle_in();
    cyc();
    chk("split_single", ALU_CE, 0);

    // Timeout: TO_ERR exactly 16 cycles after WAIT entry.
    beat(1'b1, 4'd1, 1'b0, 2'b01, 8'h55, 8'h00);
    cyc();
    idle_in();
    bad = 0;
    repeat (15) begin
      cyc();
      if (ALU_CE !== 1'b0 || TO_ERR !== 1'b0 || BUSY !== 1'b1) bad++;
    end
    chk("to_early", bad, 0);
    cyc();
    chk("to_pulse", {TO_ERR, ALU_CE, BUSY, IN_READY}, 4'b1001);
    chk("to_hold", {ALU_OPA, ALU_OPB, ALU_CMD}, {8'hA5, 8'h03, 4'd12});
    cyc();
    chk("to_one_cycle", TO_ERR, 0);

    // Completion on the last WAIT cycle wins over timeout.
    beat(1'b0, 4'd7, 1'b1, 2'b01, 8'h99, 8'h00);
    cyc();
    idle_in();
    bad = 0;
    repeat (15) begin
      cyc();
      if (ALU_CE !== 1'b0 || TO_ERR !== 1'b0) bad++;
    end
    chk("edge_early", bad, 0);
    beat(1'b0, 4'd0, 1'b0, 2'b10, 8'h00, 8'h3C);
    cyc();
    chk("edge_ce", {ALU_CE, TO_ERR}, 2'b10);
    chk("edge_data", {ALU_OPA, ALU_OPB, ALU_CMD, ALU_CIN, ALU_INP_VALID}, {8'h00, 8'h3C, 4'd7, 1'b1, 2'b10});
    idle_in();
    cyc();
    chk("edge_no_to", {TO_ERR, ALU_CE}, 2'b00);

    // Unsupported commands in both modes.
    beat(1'b0, 4'd14, 1'b0, 2'b11, 8'h01, 8'h02);
    cyc();
    chk("cerr0_pulse", {CMD_ERR, ALU_CE, BUSY, IN_READY}, 4'b1001);
    idle_in();
    cyc();
    chk("cerr0_one_cycle", CMD_ERR, 0);
    beat(1'b1, 4'd13, 1'b0, 2'b11, 8'h01, 8'h02);
    cyc();
    chk("cerr1_pulse", {CMD_ERR, ALU_CE, BUSY}, 3'b100);
    idle_in();
    cyc();

    // Single-operand commands with surplus data: unused lane zeroed.
    beat(1'b1, 4'd6, 1'b0, 2'b11, 8'hFF, 8'h07);
    cyc();
    chk("b_only", {ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB}, {1'b1, 2'b10, 8'h00, 8'h07});
    idle_in();
    cyc();
    beat(1'b1, 4'd4, 1'b0, 2'b11, 8'h3C, 8'h99);
    cyc();
    chk("a_only", {ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB}, {1'b1, 2'b01, 8'h3C, 8'h00});
    idle_in();
    cyc();

    // Reset mid-WAIT beats a concurrent completing beat.
    beat(1'b1, 4'd2, 1'b0, 2'b01, 8'h0F, 8'h00);
    cyc();
    idle_in();
    cyc();
    RST = 1'b1;
    beat(1'b1, 4'd2, 1'b0, 2'b10, 8'h00, 8'hF0);
    cyc();
    chk("mrst_ctl", {ALU_CE, BUSY, TO_ERR, CMD_ERR, IN_READY}, 5'b00001);
    chk("mrst_data", {ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_INP_VALID}, 0);
    RST = 1'b0;
    idle_in();
    bad = 0;
    repeat (20) begin
      cyc();
      if (ALU_CE !== 1'b0 || TO_ERR !== 1'b0 || CMD_ERR !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    chk("mrst_dropped", bad, 0);
    beat(1'b1, 4'd3, 1'b0, 2'b11, 8'h21, 8'h43);
    cyc();
    chk("mrst_next", {ALU_CE, ALU_OPA, ALU_OPB, ALU_CMD}, {1'b1, 8'h21, 8'h43, 4'd3});
    idle_in();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_collector.md
ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

Interface
REQ-001 SHALL have parameters: WIDTH, 8, operand width; CWIDTH, 4, command width; TIMEOUT, 16, maximum cycles spent waiting for a missing operand.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  upstream beat valid.
- IN_READY  out  1  collector can accept a beat.
- IN_CMD  in  CWIDTH  command code.
- IN_MODE  in  1  1 = arithmetic, 0 = logical.
- IN_CIN  in  1  carry-in.
- IN_OPA  in  WIDTH  operand A.
- IN_OPB  in  WIDTH  operand B.
- IN_OPV  in  2  operands carried this beat; bit1 = B, bit0 = A.
- ALU_OPA, ALU_OPB  out  WIDTH  registered operands to the ALU.
- ALU_CMD  out  CWIDTH  registered command to the ALU.
- ALU_MODE  out  1  registered mode to the ALU.
- ALU_CIN  out  1  registered carry-in to the ALU.
- ALU_INP_VALID  out  2  required-operand mask to the ALU.
- ALU_CE  out  1  one-cycle issue strobe.
- CMD_ERR  out  1  one-cycle pulse: unsupported command.
- TO_ERR  out  1  one-cycle pulse: operand wait timed out.
- BUSY  out  1  state is not IDLE.

Function
REQ-003 A beat SHALL be accepted on a rising edge where IN_VALID and IN_READY are both 1.
REQ-004 IN_READY SHALL be 1 in IDLE and WAIT and 0 in ISSUE.
REQ-005 The required mask SHALL be derived from the command beat's IN_MODE and IN_CMD:
- MODE=1: CMD 0-3 and 8-12 need 11; CMD 4-5 need 01; CMD 6-7 need 10; CMD 13-15 are unsupported.
- MODE=0: CMD 0-5, 12 and 13 need 11; CMD 6, 8 and 9 need 01; CMD 7, 10 and 11 need 10; CMD 14-15 are unsupported.
REQ-006 The state machine SHALL have three states, IDLE, WAIT and ISSUE; all outputs SHALL be registered.
REQ-007 IDLE, beat accepted with an unsupported command: CMD_ERR SHALL be 1 in the next cycle, nothing is latched, and the state stays IDLE.
REQ-008 IDLE, beat accepted with a supported command: CMD, MODE, CIN, the required mask and the supplied operands SHALL be latched.
- If IN_OPV covers the required mask, the next state SHALL be ISSUE.
- Otherwise the next state SHALL be WAIT and the wait counter SHALL be cleared to 0.
REQ-009 WAIT, beat accepted: only operands that are required and not yet held SHALL be latched (first arrival wins); the beat's IN_CMD, IN_MODE and IN_CIN SHALL be ignored.
REQ-010 WAIT: when all required operands are held, the next state SHALL be ISSUE; otherwise the counter SHALL increment each cycle.
REQ-011 WAIT: when the counter equals TIMEOUT-1 and the required operands are still incomplete, TO_ERR SHALL be 1 in the next cycle, the next state SHALL be IDLE, and latched data SHALL be discarded. A WAIT episode therefore lasts at most TIMEOUT cycles.
REQ-012 If a completing beat arrives in the timeout cycle, completion SHALL win: the next state is ISSUE and TO_ERR stays 0.
REQ-013 ISSUE SHALL last exactly one cycle, then return to IDLE.
- ALU_CE SHALL be 1 in that cycle and 0 in all other states.
- ALU_INP_VALID SHALL equal the required mask.
- Operand lanes not in the mask SHALL be driven 0.
REQ-014 Latency: a complete beat accepted at edge N SHALL give ALU_CE=1 in cycle N+1, so sustained throughput is one command per 2 cycles.
REQ-015 The ALU_* data outputs SHALL hold their last issued values while ALU_CE=0.
REQ-016 CMD_ERR and TO_ERR SHALL never both be 1 in the same cycle, and neither SHALL coincide with ALU_CE=1.
REQ-017 BUSY SHALL be 1 in WAIT and ISSUE.

Reset
REQ-018 With RST=1 at a rising edge, the next state SHALL be IDLE, the counter and held-operand flags SHALL be 0, and every output SHALL be 0, except IN_READY, which SHALL be 1 from the first cycle after reset.
REQ-019 RST SHALL take precedence over every concurrent beat, timeout or issue, including mid-WAIT and mid-ISSUE; a pending command SHALL be dropped with no ALU_CE, TO_ERR or CMD_ERR pulse.

Verification
REQ-020 Full beat: MODE=1, CMD=0, OPA=0x12, OPB=0x34, OPV=11 at edge N -> ALU_CE=1 in cycle N+1 with ALU_OPA=0x12, ALU_OPB=0x34, ALU_INP_VALID=11.
REQ-021 Split beat: MODE=0, CMD=12, OPV=01 with OPA=0xA5, then OPV=10 with OPB=0x03 three cycles later -> a single ALU_CE with ALU_CMD=12, OPA=0xA5, OPB=0x03; TO_ERR stays 0.
REQ-022 Timeout: MODE=1, CMD=1, OPV=01, then no beats -> TO_ERR=1 exactly 16 cycles after WAIT entry, no ALU_CE, BUSY=0 afterwards.
REQ-023 Boundary: a completing beat in the cycle the counter equals 15 -> ALU_CE=1 and no TO_ERR; a beat with MODE=0, CMD=14 -> CMD_ERR=1 for one cycle, no ALU_CE.
REQ-024 Single-operand command with extra data: MODE=1, CMD=6, OPV=11, OPA=0xFF, OPB=0x07 -> ALU_INP_VALID=10, ALU_OPA=0x00, ALU_OPB=0x07.
REQ-025 Reset mid-WAIT: RST=1 for one cycle after a partial beat -> IDLE, all outputs 0, no pulses; the next full beat issues normally.
